// File: rtl/round_inverse_engine.sv
// Iterative inverse of the nibble-permute/XOR/rotate round function, one inverse round per clock.
// Optional feature macro ROUND_INV_SELFCHECK_EN re-encodes the result forward and flags mismatches on out_err.
module round_inverse_engine #(
  parameter int ROUNDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_state,
  input  logic [4*ROUNDS-1:0] in_sbox,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_state,
  output logic                out_err,
  output logic                busy
);
  localparam int KW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ROUNDS - 1);
  localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] n);
    logic [7:0] d;
    d = {x, x} << n;
    return d[7:4];
  endfunction

  function automatic logic [3:0] rotr4(input logic [3:0] x, input logic [1:0] n);
    logic [7:0] d;
    d = {x, x} >> n;
    return d[3:0];
  endfunction

  // Forward round: output nibble i takes source (i+2) mod 8, XORs s, rotates left by i/2.
  function automatic logic [31:0] f_round(input logic [31:0] h, input logic [3:0] s);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = rotl4(h[4*((i + 2) % 8) +: 4] ^ s, 2'(i / 2));
    end
    return r;
  endfunction

  function automatic logic [31:0] g_round(input logic [31:0] h, input logic [3:0] s);
    logic [31:0] r;
    r = 32'd0;
    for (int j = 0; j < 8; j++) begin
      r[4*j +: 4] = rotr4(h[4*((j + 6) % 8) +: 4], 2'(((j + 6) % 8) / 2)) ^ s;
    end
    return r;
  endfunction

  state_t              state_r;
  logic [KW-1:0]       k_r;
  logic [31:0]         work_r;
  logic [4*ROUNDS-1:0] sbox_r;
  logic [31:0]         out_state_r;
  logic                out_valid_r;
  logic                out_err_r;
  logic                in_ready_r;
  logic                busy_r;
  logic [3:0]          sbox_k_s;
  logic [31:0]         inv_next_s;

`ifdef ROUND_INV_SELFCHECK_EN
  logic [31:0]   orig_r;
  logic [31:0]   chk_r;
  logic [KW-1:0] c_r;
  logic [3:0]    sbox_c_s;
  logic [31:0]   fwd_next_s;

  // Select the S-box nibble for the current re-encode round.
  always_comb begin
    sbox_c_s = 4'd0;
    for (int i = 0; i < ROUNDS; i++) begin
      sbox_c_s = (c_r == KW'(i)) ? sbox_r[4*i +: 4] : sbox_c_s;
    end
  end

  assign fwd_next_s = f_round(chk_r, sbox_c_s);
`endif

  // Select the S-box nibble for the current inverse round.
  always_comb begin
    sbox_k_s = 4'd0;
    for (int i = 0; i < ROUNDS; i++) begin
      sbox_k_s = (k_r == KW'(i)) ? sbox_r[4*i +: 4] : sbox_k_s;
    end
  end

  assign inv_next_s = g_round(work_r, sbox_k_s);

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      k_r         <= K_ZERO;
      work_r      <= 32'd0;
      sbox_r      <= {(4*ROUNDS){1'b0}};
      out_state_r <= 32'd0;
      out_valid_r <= 1'b0;
      out_err_r   <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
`ifdef ROUND_INV_SELFCHECK_EN
      orig_r      <= 32'd0;
      chk_r       <= 32'd0;
      c_r         <= K_ZERO;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            work_r     <= in_state;
            sbox_r     <= in_sbox;
            k_r        <= K_LAST;
            state_r    <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
`ifdef ROUND_INV_SELFCHECK_EN
            orig_r     <= in_state;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          work_r <= inv_next_s;
          if (k_r == K_ZERO) begin
`ifdef ROUND_INV_SELFCHECK_EN
            state_r <= CHECK;
            chk_r   <= inv_next_s;
            c_r     <= K_ZERO;
`else
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            out_state_r <= inv_next_s;
`endif
          end else begin
            k_r <= k_r - K_ONE;
          end
        end
`ifdef ROUND_INV_SELFCHECK_EN
        CHECK: begin
          chk_r <= fwd_next_s;
          if (c_r == K_LAST) begin
            out_err_r   <= (fwd_next_s != orig_r);
            out_state_r <= work_r;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            c_r <= c_r + K_ONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_state = out_state_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_round_inverse_engine.sv
// Randomized self-checking bench: two engines (ROUNDS=1 and ROUNDS=4) checked every cycle
// against a transaction-level model built from the forward/inverse round equations.
module tb_round_inverse_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [31:0] in_state  [2];
  logic [31:0] out_state [2];
  logic [15:0] in_sbox   [2];
  logic [1:0]  flip_req;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

`ifdef ROUND_INV_SELFCHECK_EN
  localparam int LATF = 2;
`else
  localparam int LATF = 1;
`endif

  round_inverse_engine #(.ROUNDS(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .in_sbox(in_sbox[0][3:0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_state(out_state[0]), .out_err(out_err[0]), .busy(busy[0]));

  round_inverse_engine #(.ROUNDS(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .in_sbox(in_sbox[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_state(out_state[1]), .out_err(out_err[1]), .busy(busy[1]));

  function automatic int rnd(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] x, input int n);
    int v;
    v = int'(x);
    return 4'(((v << n) | (v >> (4 - n))) & 15);
  endfunction

  function automatic logic [31:0] f_model(input logic [31:0] h, input logic [3:0] s);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = rotl(h[4*((i + 2) % 8) +: 4] ^ s, i / 2);
    return r;
  endfunction

  // Undo one round by scattering each nibble back to where it came from.
  function automatic logic [31:0] g_model(input logic [31:0] h, input logic [3:0] s);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 8; i++) r[4*((i + 2) % 8) +: 4] = rotl(h[4*i +: 4], (4 - i / 2) % 4) ^ s;
    return r;
  endfunction

  function automatic logic [31:0] fwd_model(input logic [31:0] h, input logic [15:0] sb, input int r);
    logic [31:0] x;
    x = h;
    for (int k = 0; k < r; k++) x = f_model(x, sb[4*k +: 4]);
    return x;
  endfunction

  function automatic logic [31:0] inv_model(input logic [31:0] h, input logic [15:0] sb, input int r);
    logic [31:0] x;
    x = h;
    for (int k = r - 1; k >= 0; k--) x = g_model(x, sb[4*k +: 4]);
    return x;
  endfunction

  // Model: 0 = idle, 1 = working (counting cycles), 2 = result presented.
  int          m_phase [2];
  int          m_cnt   [2];
  logic [31:0] m_res   [2];
  logic [31:0] m_out   [2];
  logic        m_err   [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_phase[d] = 0;
        m_out[d]   = 32'd0;
        m_err[d]   = 1'b0;
      end else begin
        case (m_phase[d])
          0: if (in_valid[d]) begin
               m_res[d]   = inv_model(in_state[d], in_sbox[d], rnd(d));
               m_cnt[d]   = LATF * rnd(d);
               m_phase[d] = 1;
             end
          1: begin
               m_cnt[d] = m_cnt[d] - 1;
               if (m_cnt[d] == 0) begin
                 m_phase[d] = 2;
                 m_out[d]   = m_res[d];
                 m_err[d]   = flip_req[d];
               end
             end
          2: if (out_ready[d]) m_phase[d] = 0;
          default: m_phase[d] = 0;
        endcase
      end
    end
  end

  task automatic chk1(input string nm, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%b required=%b t=%0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs of both engines against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk1("in_ready", d, in_ready[d], m_phase[d] == 0);
        chk1("busy", d, busy[d], m_phase[d] != 0);
        chk1("out_valid", d, out_valid[d], m_phase[d] == 2);
        chk32("out_state", d, out_state[d], m_out[d]);
        chk1("out_err", d, out_err[d], m_err[d]);
      end
    end
  end

  task automatic send(input int d, input logic [31:0] st, input logic [15:0] sb);
    int n;
    n = 0;
    while (!in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("wait_in_ready", d, in_ready[d], 1'b1);
    in_state[d] = st;
    in_sbox[d]  = sb;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic await_out(input int d);
    int n;
    n = 0;
    while (!out_valid[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("wait_out_valid", d, out_valid[d], 1'b1);
  endtask

  task automatic take(input int d);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic req(input int d, input logic [31:0] st, input logic [15:0] sb, input logic [31:0] exp);
    send(d, st, sb);
    await_out(d);
    chk32("result", d, out_state[d], exp);
    take(d);
  endtask

  task automatic req_lat(input int d, input logic [31:0] st, input logic [15:0] sb, input logic [31:0] exp);
    send(d, st, sb);
    repeat (LATF * rnd(d) - 1) @(negedge clk);
    chk1("early_valid", d, out_valid[d], 1'b0);
    @(negedge clk);
    chk1("latency_valid", d, out_valid[d], 1'b1);
    chk32("latency_result", d, out_state[d], exp);
    take(d);
  endtask

  initial begin
    logic [31:0] p;
    logic [15:0] sb;
    rst = 1'b1;
    in_valid = 2'b00;
    out_ready = 2'b00;
    flip_req = 2'b00;
    for (int d = 0; d < 2; d++) begin
      in_state[d] = 32'd0;
      in_sbox[d]  = 16'd0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk1("rst_out_valid", 1, out_valid[1], 1'b0);
    chk32("rst_out_state", 1, out_state[1], 32'd0);
    chk1("rst_busy", 1, busy[1], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_in_ready", 0, in_ready[0], 1'b1);

    // Pin the model against hand-computed vectors.
    chk32("pin_inv_a", 0, inv_model(32'h88442211, 16'h0001, 1), 32'h00000000);
    chk32("pin_inv_b", 0, inv_model(32'h80D9A832, 16'h0000, 1), 32'h76543210);
    chk32("pin_fwd_b", 0, fwd_model(32'h76543210, 16'h0000, 1), 32'h80D9A832);
    chk32("pin_fwd_a", 0, fwd_model(32'h00000000, 16'h0001, 1), 32'h88442211);

    req_lat(0, 32'h88442211, 16'h0001, 32'h00000000);
    chk1("vec_a_err", 0, out_err[0], 1'b0);
    req_lat(0, 32'h80D9A832, 16'h0000, 32'h76543210);
    req_lat(1, fwd_model(32'h12345678, 16'hA5C3, 4), 16'hA5C3, 32'h12345678);

    for (int v = 0; v < 1000; v++) begin
      p = $urandom();
      req(1, fwd_model(p, 16'hA5C3, 4), 16'hA5C3, p);
      chk1("rand_err", 1, out_err[1], 1'b0);
    end
    for (int v = 0; v < 200; v++) begin
      p  = $urandom();
      sb = 16'($urandom());
      req(v % 2, fwd_model(p, sb, rnd(v % 2)), sb, p);
    end

    // Backpressure: stall in DONE with a stray in_valid pulse.
    send(1, fwd_model(32'hCAFEF00D, 16'h3C5A, 4), 16'h3C5A);
    await_out(1);
    for (int c = 0; c < 10; c++) begin
      in_valid[1] = (c == 4);
      in_state[1] = 32'hDEADBEEF;
      @(negedge clk);
      chk1("stall_valid", 1, out_valid[1], 1'b1);
      chk32("stall_state", 1, out_state[1], 32'hCAFEF00D);
      chk1("stall_in_ready", 1, in_ready[1], 1'b0);
    end
    in_valid[1] = 1'b0;
    take(1);
    @(negedge clk);
    chk1("stray_not_taken", 1, busy[1], 1'b0);

    // Reset two cycles into RUN.
    send(1, fwd_model(32'h0BADC0DE, 16'h1234, 4), 16'h1234);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("midrst_out_valid", 1, out_valid[1], 1'b0);
    chk32("midrst_out_state", 1, out_state[1], 32'd0);
    chk1("midrst_in_ready", 1, in_ready[1], 1'b1);
    req(1, fwd_model(32'h55AA33CC, 16'h9876, 4), 16'h9876, 32'h55AA33CC);

`ifdef ROUND_INV_SELFCHECK_EN
    send(1, fwd_model(32'h13579BDF, 16'hA5C3, 4), 16'hA5C3);
    repeat (4) @(negedge clk);
    flip_req[1] = 1'b1;
    dut1.chk_r[0] = ~dut1.chk_r[0];
    await_out(1);
    chk1("flip_err", 1, out_err[1], 1'b1);
    chk32("flip_state", 1, out_state[1], 32'h13579BDF);
    take(1);
    flip_req[1] = 1'b0;
    req(1, fwd_model(32'h2468ACE0, 16'hA5C3, 4), 16'hA5C3, 32'h2468ACE0);
    chk1("clean_err", 1, out_err[1], 1'b0);
`endif

    // Random handshakes with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = 1'($urandom_range(0, 1));
        out_ready[d] = ($urandom_range(0, 3) != 0);
        in_state[d]  = $urandom();
        in_sbox[d]   = 16'($urandom());
      end
      rst = ($urandom_range(0, 150) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    in_valid = 2'b00;
    out_ready = 2'b11;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
